// File: rtl/obs_rom_arbiter.sv
// Round-robin arbiter that time-shares one obstacle sprite ROM across NUM_REQ renderers.
// Grant is combinational, the ROM port is registered, and a tag pipeline steers each colour back to its requester.
module obs_rom_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int TYPE_W  = 3,
    parameter int ROM_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_counter,
    input  logic [NUM_REQ*TYPE_W-1:0] i_req_type,
    output logic [NUM_REQ-1:0]        o_gnt,
    output logic                      o_rom_en,
    output logic [ADDR_W-1:0]         o_rom_counter,
    output logic [TYPE_W-1:0]         o_rom_type,
    input  logic                      i_rom_color,
    output logic [NUM_REQ-1:0]        o_resp_valid,
    output logic [NUM_REQ-1:0]        o_sprite_color
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DEPTH = 1 + ROM_LAT;

    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  win;
    logic [IDX_W-1:0]  cand;
    logic              gnt_any;
    logic [NUM_REQ-1:0] gnt;
    logic [ADDR_W-1:0] sel_counter;
    logic [TYPE_W-1:0] sel_type;

    logic [DEPTH-1:0]  tag_vld;
    logic [IDX_W-1:0]  tag_idx [DEPTH];

    // Search starts one past the last winner; modulo keeps non-power-of-two counts fair.
    always_comb begin
        gnt_any = 1'b0;
        win     = '0;
        cand    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!gnt_any && i_req[cand]) begin
                gnt_any = 1'b1;
                win     = cand;
            end
        end
        if (rst) begin
            gnt_any = 1'b0;
        end
        gnt = '0;
        if (gnt_any) begin
            gnt[win] = 1'b1;
        end
    end

    always_comb begin
        sel_counter = '0;
        sel_type    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                sel_counter = i_req_counter[k*ADDR_W +: ADDR_W];
                sel_type    = i_req_type[k*TYPE_W +: TYPE_W];
            end
        end
    end

    assign o_gnt = gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr            <= IDX_W'(NUM_REQ - 1);
            o_rom_en       <= 1'b0;
            o_rom_counter  <= '0;
            o_rom_type     <= '0;
            tag_vld        <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                tag_idx[j] <= '0;
            end
            o_resp_valid   <= '0;
            o_sprite_color <= '0;
        end else begin
            o_rom_en <= gnt_any;
            if (gnt_any) begin
                ptr           <= win;
                o_rom_counter <= sel_counter;
                o_rom_type    <= sel_type;
            end

            tag_vld    <= {tag_vld[DEPTH-2:0], gnt_any};
            tag_idx[0] <= win;
            for (int j = 1; j < DEPTH; j++) begin
                tag_idx[j] <= tag_idx[j-1];
            end

            // Tail of the tag pipe lines up with the ROM data for that lookup.
            o_resp_valid <= '0;
            if (tag_vld[DEPTH-1]) begin
                o_resp_valid[tag_idx[DEPTH-1]]   <= 1'b1;
                o_sprite_color[tag_idx[DEPTH-1]] <= i_rom_color;
            end
        end
    end

endmodule

// File: tb/tb_obs_rom_arbiter.sv
// Directed bench for obs_rom_arbiter: a default 2-requester instance and a 3-requester, 2-cycle ROM instance.
module tb_obs_rom_arbiter;

    logic        clk;
    logic        rst;

    logic [1:0]  req_a;
    logic [15:0] cnt_a;
    logic [5:0]  type_a;
    logic [1:0]  gnt_a;
    logic        en_a;
    logic [7:0]  rcnt_a;
    logic [2:0]  rtype_a;
    logic        rom_a;
    logic [1:0]  resp_a;
    logic [1:0]  spr_a;

    logic [2:0]  req_b;
    logic [23:0] cnt_b;
    logic [8:0]  type_b;
    logic [2:0]  gnt_b;
    logic        en_b;
    logic [7:0]  rcnt_b;
    logic [2:0]  rtype_b;
    logic        rom_b1;
    logic        rom_b2;
    logic [2:0]  resp_b;
    logic [2:0]  spr_b;

    int total = 0;
    int bad   = 0;

    obs_rom_arbiter #(.NUM_REQ(2), .ADDR_W(8), .TYPE_W(3), .ROM_LAT(1)) dut_a (
        .clk(clk), .rst(rst),
        .i_req(req_a), .i_req_counter(cnt_a), .i_req_type(type_a),
        .o_gnt(gnt_a), .o_rom_en(en_a), .o_rom_counter(rcnt_a), .o_rom_type(rtype_a),
        .i_rom_color(rom_a), .o_resp_valid(resp_a), .o_sprite_color(spr_a)
    );

    obs_rom_arbiter #(.NUM_REQ(3), .ADDR_W(8), .TYPE_W(3), .ROM_LAT(2)) dut_b (
        .clk(clk), .rst(rst),
        .i_req(req_b), .i_req_counter(cnt_b), .i_req_type(type_b),
        .o_gnt(gnt_b), .o_rom_en(en_b), .o_rom_counter(rcnt_b), .o_rom_type(rtype_b),
        .i_rom_color(rom_b2), .o_resp_valid(resp_b), .o_sprite_color(spr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sprite ROM stand-in: colour is counter bit 0 xor type bit 0.
    function automatic logic rom_fn(input logic [7:0] c, input logic [2:0] t);
        return c[0] ^ t[0];
    endfunction

    always @(posedge clk) begin
        rom_a  <= rom_fn(rcnt_a, rtype_a);
        rom_b1 <= rom_fn(rcnt_b, rtype_b);
        rom_b2 <= rom_b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req_a = '0;
        req_b = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    logic [1:0] eg2, er2;
    logic [2:0] eg3, er3;

    initial begin
        rst = 1'b1;
        req_a = '0; cnt_a = '0; type_a = '0;
        req_b = '0; cnt_b = '0; type_b = '0;

        // Reset: grant suppressed while rst is high, registered outputs cleared
        cyc();
        req_a = 2'b11;
        #1 chk("rst_gnt", 32'(gnt_a), 32'h0);
        cyc();
        #1;
        chk("rst_en", 32'(en_a), 32'h0);
        chk("rst_cnt", 32'(rcnt_a), 32'h0);
        chk("rst_type", 32'(rtype_a), 32'h0);
        chk("rst_resp", 32'(resp_a), 32'h0);
        chk("rst_color", 32'(spr_a), 32'h0);
        chk("rst_gnt_b", 32'(gnt_b), 32'h0);
        rst = 1'b0;
        req_a = '0;

        // Single requester, counter 0x25 type 2 -> colour 1
        cyc();
        req_a = 2'b01; cnt_a = {8'h00, 8'h25}; type_a = {3'd0, 3'd2};
        #1 chk("t1_gnt", 32'(gnt_a), 32'h1);
        cyc();
        req_a = 2'b00;
        #1;
        chk("t1_en", 32'(en_a), 32'h1);
        chk("t1_cnt", 32'(rcnt_a), 32'h25);
        chk("t1_type", 32'(rtype_a), 32'h2);
        chk("t1_gnt_idle", 32'(gnt_a), 32'h0);
        cyc();
        #1;
        chk("t1_en_off", 32'(en_a), 32'h0);
        chk("t1_cnt_hold", 32'(rcnt_a), 32'h25);
        chk("t1_resp_early", 32'(resp_a), 32'h0);
        cyc();
        #1;
        chk("t1_resp", 32'(resp_a), 32'h1);
        chk("t1_color", 32'(spr_a), 32'h1);
        cyc();
        #1;
        chk("t1_resp_pulse", 32'(resp_a), 32'h0);
        chk("t1_color_hold", 32'(spr_a), 32'h1);

        // Contention: both held 6 cycles; both colours are 1
        do_reset();
        cnt_a = {8'h03, 8'h01}; type_a = '0;
        for (int i = 0; i < 9; i++) begin
            cyc();
            req_a = (i < 6) ? 2'b11 : 2'b00;
            #1;
            eg2 = (i < 6) ? ((i % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
            er2 = (i >= 3 && i < 9) ? (((i - 3) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
            chk($sformatf("t2_gnt%0d", i), 32'(gnt_a), 32'(eg2));
            chk($sformatf("t2_resp%0d", i), 32'(resp_a), 32'(er2));
            if (i >= 1 && i <= 6)
                chk($sformatf("t2_cnt%0d", i), 32'(rcnt_a), ((i - 1) % 2 == 1) ? 32'h03 : 32'h01);
        end
        chk("t2_color", 32'(spr_a), 32'h3);

        // Pointer memory: lone grant to 1, idle, then both -> 0 first, then 1
        do_reset();
        cyc();
        req_a = 2'b10;
        #1 chk("t3_gnt1", 32'(gnt_a), 32'h2);
        for (int i = 0; i < 5; i++) begin
            cyc();
            req_a = 2'b00;
            #1 chk($sformatf("t3_idle%0d", i), 32'(gnt_a), 32'h0);
        end
        cyc();
        req_a = 2'b11;
        #1 chk("t3_first", 32'(gnt_a), 32'h1);
        cyc();
        #1 chk("t3_second", 32'(gnt_a), 32'h2);
        cyc();
        req_a = 2'b00;

        // Hold: requester 0 gets 1, requester 1 gets 0, bit 0 keeps its value
        do_reset();
        cnt_a = {8'h02, 8'h01}; type_a = '0;
        cyc();
        req_a = 2'b01;
        #1 chk("t4_gnt0", 32'(gnt_a), 32'h1);
        cyc();
        req_a = 2'b10;
        #1 chk("t4_gnt1", 32'(gnt_a), 32'h2);
        cyc();
        req_a = 2'b00;
        #1 chk("t4_color_pre", 32'(spr_a), 32'h0);
        cyc();
        #1;
        chk("t4_resp0", 32'(resp_a), 32'h1);
        chk("t4_color0", 32'(spr_a), 32'h1);
        cyc();
        #1;
        chk("t4_resp1", 32'(resp_a), 32'h2);
        chk("t4_color1", 32'(spr_a), 32'h1);
        cyc();
        #1;
        chk("t4_resp_end", 32'(resp_a), 32'h0);
        chk("t4_color_end", 32'(spr_a), 32'h1);

        // Reset mid-flight: lookup from before reset never responds
        do_reset();
        cnt_a = {8'h00, 8'h01}; type_a = '0;
        cyc();
        req_a = 2'b01;
        #1 chk("t5_gnt", 32'(gnt_a), 32'h1);
        cyc();
        rst = 1'b1;
        #1 chk("t5_gnt_rst", 32'(gnt_a), 32'h0);
        cyc();
        rst = 1'b0;
        #1;
        chk("t5_en", 32'(en_a), 32'h0);
        chk("t5_cnt", 32'(rcnt_a), 32'h0);
        chk("t5_resp", 32'(resp_a), 32'h0);
        chk("t5_color", 32'(spr_a), 32'h0);
        chk("t5_gnt_post", 32'(gnt_a), 32'h1);
        cyc();
        req_a = 2'b00;
        #1;
        chk("t5_resp_t3", 32'(resp_a), 32'h0);
        chk("t5_en_post", 32'(en_a), 32'h1);
        cyc();
        #1 chk("t5_resp_t4", 32'(resp_a), 32'h0);
        cyc();
        #1;
        chk("t5_resp_t5", 32'(resp_a), 32'h1);
        chk("t5_color_t5", 32'(spr_a), 32'h1);

        // Three requesters, 2-cycle ROM: colours 1,0,1
        do_reset();
        cnt_b = {8'h33, 8'h20, 8'h11}; type_b = '0;
        for (int i = 0; i < 11; i++) begin
            cyc();
            req_b = (i < 6) ? 3'b111 : 3'b000;
            #1;
            eg3 = (i < 6) ? 3'(1 << (i % 3)) : 3'b000;
            er3 = (i >= 4 && i < 10) ? 3'(1 << ((i - 4) % 3)) : 3'b000;
            chk($sformatf("t6_gnt%0d", i), 32'(gnt_b), 32'(eg3));
            chk($sformatf("t6_resp%0d", i), 32'(resp_b), 32'(er3));
        end
        chk("t6_color", 32'(spr_b), 32'h5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
